// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared types and constants for the PWM capture block.
// Optional feature macro: PWM_CAPTURE_SYNC_EN (adds a 2-flop input synchronizer).
package pwm_capture_pkg;

  // Top-level control state: wait for a period boundary, then measure whole periods.
  typedef enum logic {
    ALIGN   = 1'b0,
    MEASURE = 1'b1
  } state_e;

  // Latency of the optional PWM_IN synchronizer, in clocks.
  localparam int unsigned SYNC_LAT = 2;

endpackage

// File: rtl/pwm_capture_edge.sv
// pwm_capture_edge: conditions PWM_IN and produces the per-clock sample plus
// rise/fall strobes relative to the previous sample.
// With PWM_CAPTURE_SYNC_EN defined, PWM_IN first passes a SYNC_LAT-flop synchronizer.
module pwm_capture_edge
  import pwm_capture_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic sample,
  output logic rise,
  output logic fall
);

`ifdef PWM_CAPTURE_SYNC_EN
  logic [SYNC_LAT-1:0] sync_q;

  // Shift PWM_IN through the synchronizer chain.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_LAT-2:0], pwm_in};
    end
  end

  assign sample = sync_q[SYNC_LAT-1];
`else
  assign sample = pwm_in;
`endif

  logic prev_q;

  // Remember the previous sample; reset treats it as low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sample;
    end
  end

  assign rise = sample & ~prev_q;
  assign fall = ~sample & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: decodes rise time, fall time and high-sample count of a PWM
// waveform against a free-running period counter, one result per period.
// With PWM_CAPTURE_SYNC_EN defined, PWM_IN is synchronized and edge times are
// corrected by -SYNC_LAT mod CYCLE.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned CYCLE = 4096
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] TIME_CNT,
  input  logic             PWM_IN,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] DUTY,
  output logic             VALID,
  output logic             GLITCH,
  output logic             LOST
);

`ifdef PWM_CAPTURE_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif
  localparam int unsigned     EDGE_LAT = SYNC_EN ? SYNC_LAT : 0;
  localparam logic [WIDTH-1:0] LAST_T  = WIDTH'(CYCLE - 1);
  localparam logic [WIDTH-1:0] CYC_W   = WIDTH'(CYCLE);

  // Per-period accumulators; cleared at every period boundary.
  typedef struct packed {
    logic             rise_seen;
    logic [WIDTH-1:0] rise_t;
    logic             fall_seen;
    logic [WIDTH-1:0] fall_t;
    logic             glitch;
    logic [WIDTH-1:0] duty;
  } acc_t;

  state_e           state_q;
  acc_t             acc_q;
  acc_t             acc_n;
  logic [WIDTH-1:0] t_prev_q;
  logic             t_prev_vld_q;
  logic [WIDTH-1:0] t_exp;
  logic             discont;
  logic             is_last;
  logic [WIDTH-1:0] edge_t;
  logic [WIDTH-1:0] pub_rise;
  logic [WIDTH-1:0] pub_fall;
  logic             sample_s;
  logic             rise_s;
  logic             fall_s;

  pwm_capture_edge u_edge (
    .clk    (CLK),
    .rst_n  (RST_N),
    .pwm_in (PWM_IN),
    .sample (sample_s),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  // A sample is continuous when it is the wrap-around successor of the last one.
  assign t_exp   = (t_prev_q == LAST_T) ? '0 : t_prev_q + 1'b1;
  assign discont = t_prev_vld_q && (TIME_CNT != t_exp);
  assign is_last = (TIME_CNT == LAST_T);

  // Edge time stamp, pulled back by the synchronizer latency when present.
  generate
    if (EDGE_LAT == 0) begin : g_no_corr
      assign edge_t = TIME_CNT;
    end else begin : g_corr
      assign edge_t = (TIME_CNT >= WIDTH'(EDGE_LAT)) ? TIME_CNT - WIDTH'(EDGE_LAT)
                                                     : TIME_CNT + WIDTH'(CYCLE - EDGE_LAT);
    end
  endgenerate

  // Fold the current sample into the accumulators and form the canonical result.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    acc_n    = acc_q;
    pub_rise = '0;
    pub_fall = '0;

    if (rise_s) begin
      if (acc_q.rise_seen) begin
        acc_n.glitch = 1'b1;
      end else begin
        acc_n.rise_seen = 1'b1;
        acc_n.rise_t    = edge_t;
      end
    end

    // A fall at time 0 is the tail of the previous period's pulse, not a new edge.
    if (fall_s && (edge_t != '0)) begin
      if (acc_q.fall_seen) begin
        acc_n.glitch = 1'b1;
      end else begin
        acc_n.fall_seen = 1'b1;
        acc_n.fall_t    = edge_t;
      end
    end

    if (sample_s && (acc_q.duty != CYC_W)) begin
      acc_n.duty = acc_q.duty + 1'b1;
    end

    if (acc_n.rise_seen) begin
      pub_rise = acc_n.rise_t;
      pub_fall = acc_n.fall_seen ? acc_n.fall_t : CYC_W;
    end else if (acc_n.fall_seen) begin
      pub_fall = acc_n.fall_t;
    end else if (sample_s) begin
      pub_fall = CYC_W;
    end
  end

  // Control FSM: align to the period, measure, publish at the boundary, drop on discontinuity.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ALIGN;
      acc_q        <= '0;
      t_prev_q     <= '0;
      t_prev_vld_q <= 1'b0;
      RISE         <= '0;
      FALL         <= '0;
      DUTY         <= '0;
      VALID        <= 1'b0;
      GLITCH       <= 1'b0;
      LOST         <= 1'b0;
    end else begin
      t_prev_q     <= TIME_CNT;
      t_prev_vld_q <= 1'b1;
      VALID        <= 1'b0;
      if (discont) begin
        LOST    <= 1'b1;
        state_q <= ALIGN;
        acc_q   <= '0;
      end else begin
        case (state_q)
          ALIGN: begin
            acc_q <= '0;
            if (is_last) begin
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (is_last) begin
              RISE   <= pub_rise;
              FALL   <= pub_fall;
              DUTY   <= acc_n.duty;
              GLITCH <= acc_n.glitch;
              VALID  <= 1'b1;
              acc_q  <= '0;
            end else begin
              acc_q <= acc_n;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture (WIDTH=13, CYCLE=4096) driven
// by a behavioural PWM generator and a continuous period counter.
module tb_pwm_capture;

  localparam int unsigned WIDTH = 13;
  localparam int unsigned CYCLE = 4096;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [WIDTH-1:0] TIME_CNT;
  logic             PWM_IN;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic [WIDTH-1:0] DUTY;
  logic             VALID;
  logic             GLITCH;
  logic             LOST;

  int checks   = 0;
  int failures = 0;

  // Observations collected by drive()
  int               vcount;
  int               last_vt;
  logic [WIDTH-1:0] cap_rise;
  logic [WIDTH-1:0] cap_fall;
  logic [WIDTH-1:0] cap_duty;
  logic             cap_glitch;

  always #5 CLK = ~CLK;

  pwm_capture #(
    .WIDTH (WIDTH),
    .CYCLE (CYCLE)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .TIME_CNT (TIME_CNT),
    .PWM_IN   (PWM_IN),
    .RISE     (RISE),
    .FALL     (FALL),
    .DUTY     (DUTY),
    .VALID    (VALID),
    .GLITCH   (GLITCH),
    .LOST     (LOST)
  );

  // PWM generator: high on [r, f) when r <= f, otherwise wrapped high on [r, CYCLE) and [0, f).
  function automatic logic gen(input int t, input int r, input int f, input bit extra);
    logic h;
    if (r <= f) h = (t >= r) && (t < f);
    else        h = (t >= r) || (t < f);
    if (extra && (t == 100 || t == 101)) h = 1'b1;
    return h;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive counter values lo..hi with the generator waveform, noting every VALID pulse.
  task automatic drive(input int lo, input int hi, input int r, input int f, input bit extra);
    vcount  = 0;
    last_vt = -1;
    for (int t = lo; t <= hi; t++) begin
      TIME_CNT = WIDTH'(t);
      PWM_IN   = gen(t, r, f, extra);
      @(posedge CLK);
      #1;
      if (VALID === 1'b1) begin
        vcount++;
        last_vt    = t;
        cap_rise   = RISE;
        cap_fall   = FALL;
        cap_duty   = DUTY;
        cap_glitch = GLITCH;
      end
    end
  endtask

  task automatic check_period(input string tag, input int er, input int ef, input int ed,
                              input bit eg);
    check({tag, ".valid_cnt"}, vcount, 1);
    check({tag, ".valid_t"}, last_vt, CYCLE - 1);
    check({tag, ".rise"}, cap_rise, er);
    check({tag, ".fall"}, cap_fall, ef);
    check({tag, ".duty"}, cap_duty, ed);
    check({tag, ".glitch"}, cap_glitch, eg);
  endtask

  initial begin
    RST_N    = 1'b0;
    TIME_CNT = '0;
    PWM_IN   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst.rise", RISE, 0);
    check("rst.fall", FALL, 0);
    check("rst.duty", DUTY, 0);
    check("rst.valid", VALID, 0);
    check("rst.glitch", GLITCH, 0);
    check("rst.lost", LOST, 0);
    RST_N = 1'b1;

    // Alignment period: no result yet
    drive(0, CYCLE - 1, 1024, 3072, 1'b0);
    check("align.valid_cnt", vcount, 0);

    drive(0, CYCLE - 1, 1024, 3072, 1'b0);
    check_period("p1024_3072", 1024, 3072, 2048, 1'b0);

    // Extra pulse at 100..101: first rise/fall win, glitch flagged
    drive(0, CYCLE - 1, 1024, 3072, 1'b1);
    check_period("glitch", 100, 102, 2050, 1'b1);

    drive(0, CYCLE - 1, 1024, 3072, 1'b0);
    check_period("clean", 1024, 3072, 2048, 1'b0);

    // Wrapped pulse; first period is a transition and is not examined
    drive(0, CYCLE - 1, 3072, 1024, 1'b0);
    drive(0, CYCLE - 1, 3072, 1024, 1'b0);
    check_period("wrap", 3072, 1024, 2048, 1'b0);

    drive(0, CYCLE - 1, 0, 4096, 1'b0);
    check_period("all_high", 0, 4096, 4096, 1'b0);

    drive(0, CYCLE - 1, 2048, 2048, 1'b0);
    check_period("all_low", 0, 0, 0, 1'b0);

    drive(0, CYCLE - 1, 4096, 2048, 1'b0);
    check_period("fall_only", 0, 2048, 2048, 1'b0);

    drive(0, CYCLE - 1, 2048, 0, 1'b0);
    check_period("rise_only", 2048, 4096, 2048, 1'b0);

    // Counter jump 500 -> 900: period discarded, LOST sticky, outputs hold
    drive(0, 500, 1024, 3072, 1'b0);
    check("pre_jump.valid_cnt", vcount, 0);
    check("hold.rise", RISE, 2048);
    check("hold.fall", FALL, 4096);
    drive(900, 900, 1024, 3072, 1'b0);
    check("jump.lost", LOST, 1);
    drive(901, CYCLE - 1, 1024, 3072, 1'b0);
    check("jump.valid_cnt", vcount, 0);
    drive(0, 1000, 1024, 3072, 1'b0);
    check("mid.valid_cnt", vcount, 0);
    check("mid.lost", LOST, 1);

    // Reset mid-period
    RST_N = 1'b0;
    #1;
    check("mrst.lost", LOST, 0);
    check("mrst.valid", VALID, 0);
    check("mrst.rise", RISE, 0);
    check("mrst.fall", FALL, 0);
    check("mrst.duty", DUTY, 0);
    drive(1001, 1002, 1024, 3072, 1'b0);
    RST_N = 1'b1;
    drive(1003, CYCLE - 1, 1024, 3072, 1'b0);
    check("realign.valid_cnt", vcount, 0);
    drive(0, CYCLE - 1, 1024, 3072, 1'b0);
    check_period("post_rst", 1024, 3072, 2048, 1'b0);
    check("post_rst.lost", LOST, 0);

    // VALID lasts exactly one clock
    drive(0, 0, 1024, 3072, 1'b0);
    check("pulse_end.valid_cnt", vcount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
